inv_addkey_mixcol: RTL and testbench



---
 rtl/aes_dec_pkg.sv | 51 +++++
 rtl/inv_mixcol_word.sv | 20 ++
 rtl/inv_addkey_mixcol.sv | 108 ++++++++++
 tb/tb_inv_addkey_mixcol.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption round datapath: state encoding,
// widths, and GF(2^8) constant multipliers built from xtime chains.
package aes_dec_pkg;

   localparam int STATE_W = 128;
   localparam int COL_W   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MIX  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul9(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] gmul11(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] gmul13(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] gmul14(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

endpackage

// File: rtl/inv_mixcol_word.sv
// InvMixColumns applied to one 32-bit state column; purely combinational.
// Byte a0 is the most significant byte of the word.
module inv_mixcol_word
   import aes_dec_pkg::*;
(
   input  logic [COL_W-1:0] word,
   output logic [COL_W-1:0] mixed
);

   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      {a0, a1, a2, a3} = word;
      mixed[31:24] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
      mixed[23:16] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
      mixed[15:8]  = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
      mixed[7:0]   = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
   end

endmodule

// File: rtl/inv_addkey_mixcol.sv
// Decryption round stage: AddRoundKey on accept, then column-serial
// InvMixColumns (one column per clock), bypassed on the final round.
module inv_addkey_mixcol
   import aes_dec_pkg::*;
#(
   parameter int NCOL = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_data,
   input  logic [STATE_W-1:0] in_key,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_data
);

   state_t             state, state_nxt;
   logic [STATE_W-1:0] st;
   logic [1:0]         col;
   logic               last;
   logic [COL_W-1:0]   col_word, col_mixed;
   logic               col_end;

   assign col_end = (col == 2'(NCOL - 1));

   always_comb begin
      col_word = st[127:96];
      case (col)
         2'd0: col_word = st[127:96];
         2'd1: col_word = st[95:64];
         2'd2: col_word = st[63:32];
         2'd3: col_word = st[31:0];
         default: col_word = st[127:96];
      endcase
   end

   inv_mixcol_word u_mixcol (
      .word  (col_word),
      .mixed (col_mixed)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = in_last ? DONE : MIX;
         end
         MIX: begin
            if (col_end) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register is only written on accept and during MIX, so it holds
   // steady under backpressure in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= '0;
         col  <= 2'd0;
         last <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  st   <= in_data ^ in_key;
                  last <= in_last;
                  col  <= 2'd0;
               end
            end
            MIX: begin
               if (!last) begin
                  case (col)
                     2'd0: st[127:96] <= col_mixed;
                     2'd1: st[95:64]  <= col_mixed;
                     2'd2: st[63:32]  <= col_mixed;
                     2'd3: st[31:0]   <= col_mixed;
                     default: st[127:96] <= col_mixed;
                  endcase
               end
               col <= col_end ? 2'd0 : col + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign out_data = st;

endmodule

// File: tb/tb_inv_addkey_mixcol.sv
// Scoreboard bench for inv_addkey_mixcol: expected round results are queued
// on accept and compared when the DUT hands a result downstream.
module tb_inv_addkey_mixcol;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_key;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   int n_checks = 0;
   int n_fail   = 0;
   logic [127:0] sb[$];

   always #5 clk = ~clk;

   inv_addkey_mixcol #(.NCOL(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Shift-and-add GF(2^8) multiply, independent of the xtime chain form.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k,
                                              input logic lst);
      logic [127:0] s, r;
      logic [7:0] m [4][4];
      logic [7:0] a [4];
      logic [7:0] acc;
      m[0] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      m[1] = '{8'h09, 8'h0e, 8'h0b, 8'h0d};
      m[2] = '{8'h0d, 8'h09, 8'h0e, 8'h0b};
      m[3] = '{8'h0b, 8'h0d, 8'h09, 8'h0e};
      s = d ^ k;
      if (lst) return s;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
         for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(m[i][j], a[j]);
            r[127 - 32*c - 8*i -: 8] = acc;
         end
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) check("sb_nonempty", 128'(sb.size()), 128'd1);
         else check("out_data", out_data, sb.pop_front());
      end
   end

   // Drives one state, checks accept-to-out_valid edge count and that
   // in_ready stays low while busy; inputs are scrambled after accept.
   task automatic send(input logic [127:0] d, input logic [127:0] k, input logic lst,
                       input int exp_lat);
      int n;
      @(negedge clk);
      in_data = d; in_key = k; in_last = lst; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (!in_ready) check("accept_timeout", 128'(in_ready), 128'd1);
      @(posedge clk);
      sb.push_back(ref_round(d, k, lst));
      #1;
      in_valid = 1'b0;
      in_key   = ~k;
      in_last  = ~lst;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      check("busy_in_ready", 128'(in_ready), 128'd0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1; n++;
         check("busy_in_ready", 128'(in_ready), 128'd0);
      end
      check("latency", 128'(n), 128'(exp_lat));
   endtask

   task automatic finish_handshake();
      int n = 0;
      while (out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("ready_after_hs", 128'(in_ready), 128'd1);
   endtask

   localparam logic [127:0] V1   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V1_R = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] KC   = 128'h0123456789abcdeffedcba9876543210;

   initial begin
      logic [127:0] held;
      logic [127:0] d, k;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; in_last = 1'b0;
      out_ready = 1'b1;
      #12;
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_out_data", out_data, 128'd0);
      @(negedge clk); rst_n = 1'b1;

      // Known-answer normal round and its reference model
      check("model_kat", ref_round(V1, 128'd0, 1'b0), V1_R);
      send(V1, 128'd0, 1'b0, 4);
      check("kat_data", out_data, V1_R);
      finish_handshake();

      send(128'd0, {128{1'b1}}, 1'b1, 0);
      check("last_data", out_data, {128{1'b1}});
      finish_handshake();

      send(KC, KC, 1'b0, 4);
      check("cancel_data", out_data, 128'd0);
      finish_handshake();

      // Backpressure with an ignored in_valid pulse
      out_ready = 1'b0;
      send(V1, KC, 1'b0, 4);
      held = out_data;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin in_valid = 1'b1; in_data = KC; in_last = 1'b1; end
         if (i == 4) in_valid = 1'b0;
         @(posedge clk); #1;
         check("bp_data", out_data, held);
         check("bp_valid", 128'(out_valid), 128'd1);
         check("bp_in_ready", 128'(in_ready), 128'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 128'(out_valid), 128'd0);
      check("bp_release_ready", 128'(in_ready), 128'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("bp_no_ghost", 128'(out_valid), 128'd0);
      end

      // Random normal and last rounds
      for (int i = 0; i < 6; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         k = {$urandom, $urandom, $urandom, $urandom};
         send(d, k, i[0], i[0] ? 0 : 4);
         finish_handshake();
      end

      // Reset in the middle of MIX
      @(negedge clk);
      in_data = KC; in_key = V1; in_last = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 128'(out_valid), 128'd0);
      check("midrst_in_ready", 128'(in_ready), 128'd1);
      check("midrst_out_data", out_data, 128'd0);
      @(negedge clk); rst_n = 1'b1;
      send(V1, 128'd0, 1'b0, 4);
      check("post_rst_data", out_data, V1_R);
      finish_handshake();

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 128'(sb.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
